// File: rtl/cla_multiword_sequencer.sv
// Multi-precision add/subtract sequencer: one 8-bit carry-lookahead slice is
// reused across BYTES cycles, LSB byte first, chaining the carry between bytes.
module cla_multiword_sequencer #(
    parameter int BYTES = 4,
    localparam int WIDTH = 8 * BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid/ready never depend combinationally on each other.

    localparam int IDX_W = $clog2(BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] slice_g;
    logic [7:0] slice_p;
    logic [7:0] slice_c;
    logic [7:0] slice_sum;

    // Each carry is formed directly from generate/propagate terms and cin,
    // so no carry depends on a lower carry within the slice.
    function automatic logic [7:0] cla_carries(input logic [7:0] g,
                                               input logic [7:0] p,
                                               input logic       cin);
        logic [7:0] c;
        logic       term;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    assign slice_a   = a_reg[idx*8 +: 8];
    assign slice_b   = b_reg[idx*8 +: 8];
    assign slice_g   = slice_a & slice_b;
    assign slice_p   = slice_a ^ slice_b;
    assign slice_c   = cla_carries(slice_g, slice_p, carry);
    assign slice_sum = slice_p ^ {slice_c[6:0], carry};

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE) && !rst;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1; the +1 enters as the first carry.
                        a_reg <= in_a;
                        b_reg <= in_sub ? ~in_b : in_b;
                        carry <= in_sub;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_sum[idx*8 +: 8] <= slice_sum;
                    carry               <= slice_c[7];
                    idx                 <= idx + 1'b1;
                    if (idx == IDX_W'(BYTES - 1)) begin
                        out_cout <= slice_c[7];
                        out_ovf  <= slice_c[6] ^ slice_c[7];
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Bench for cla_multiword_sequencer (BYTES=4): directed cases plus random
// add/subtract operations checked against an arithmetic reference model.
module tb_cla_multiword_sequencer;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic [1:0]   dbg_state;

    int n_assert;
    int n_fail;

    logic [W+1:0] exp_q[$];

    cla_multiword_sequencer #(.BYTES(BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        longint ua, ub, sa, sb, r;
        logic [W-1:0] s;
        logic cout, ovf;
        ua = longint'(a);
        ub = longint'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            s    = a - b;
            cout = (ua >= ub);
            r    = sa - sb;
        end else begin
            s    = W'(ua + ub);
            cout = ((ua + ub) >> W) != 0;
            r    = sa + sb;
        end
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ovf, cout, s};
    endfunction

    // driver: present one op, wait for result, check latency and value, release it
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
        logic [W+1:0] exp;
        int cyc;
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, in_ready, 1'b1);
        exp_q.push_back(model(a, b, sub));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, BYTES + 1);
        exp = exp_q.pop_front();
        check({tag, "_sum"},  out_sum,  exp[W-1:0]);
        check({tag, "_cout"}, out_cout, exp[W]);
        check({tag, "_ovf"},  out_ovf,  exp[W+1]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         held_ovf;
        logic [W+1:0] exp;
        int           cyc;

        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum",   out_sum,   '0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_cout", out_cout, 1'b0);
        check("post_rst_ovf",  out_ovf,  1'b0);
        @(negedge clk);

        run_op("single_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
        run_op("full_ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("signed_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("sub_neg",      32'h0000_0005, 32'h0000_0007, 1'b1);
        run_op("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1);

        // directed constants cross-checked against the model itself
        check("model_single", model(32'h0000_00FF, 32'h1, 1'b0), {2'b00, 32'h0000_0100});
        check("model_sub_ovf", model(32'h8000_0000, 32'h1, 1'b1), {2'b11, 32'h7FFF_FFFF});

        // backpressure: result held for 10 cycles while a new op is offered
        exp = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        in_valid = 1'b1;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h1234_5678;
        in_sub   = 1'b0;
        @(negedge clk);
        in_a   = 32'h0BAD_F00D;
        in_b   = 32'h1111_2222;
        in_sub = 1'b1;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", cyc, BYTES + 1);
        check("bp_sum", out_sum, exp[W-1:0]);
        held_sum  = out_sum;
        held_cout = out_cout;
        held_ovf  = out_ovf;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_hold", out_valid, 1'b1);
            check("bp_in_ready",   in_ready,  1'b0);
            check("bp_sum_hold",   out_sum,   held_sum);
            check("bp_flags_hold", {out_cout, out_ovf}, {held_cout, held_ovf});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready,  1'b1);
        run_op("bp_next", 32'h0BAD_F00D, 32'h1111_2222, 1'b1);

        // reset while byte 2 is being computed
        in_valid = 1'b1;
        in_a     = 32'hAAAA_AAAA;
        in_b     = 32'h5555_5555;
        in_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready",  in_ready,  1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_sum",   out_sum,   '0);
        @(negedge clk);
        check("mid_rst_no_result", out_valid, 1'b0);
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0);
        check("after_rst_const", out_sum, 32'h2345_6789);

        // random operations
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) rb = '1;
            run_op("random", ra, rb, rs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_multiword_sequencer.md
# cla_multiword_sequencer

Multi-precision add/subtract controller that time-shares one 8-bit carry-lookahead adder slice across a wide operand. It accepts a WIDTH-bit operation over a valid/ready handshake and runs it one byte per cycle, LSB byte first, feeding each byte's carry-out into the next byte's carry-in. It returns the sum with carry-out and signed overflow over a second valid/ready handshake. It sits between a register-file or host interface and the adder datapath, and is the sequencing layer for anything wider than 8 bits.

## Interface
- BYTES, default 4, number of 8-bit slices per operation; legal range 2..16.
- WIDTH, default 8*BYTES, operand width; derived and not overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented on in_a, in_b and in_sub.
- in_ready  output  1  the block can accept an operation; high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  selects the operation: 0 = A+B, 1 = A-B.
- out_valid  output  1  the result is valid; high only in DONE.
- out_ready  input  1  the consumer accepts the result.
- out_sum  output  WIDTH  the result modulo 2^WIDTH.
- out_cout  output  1  carry-out of the MSB byte; for subtract, 1 means no borrow.
- out_ovf  output  1  signed two's-complement overflow.

## Operation
- **Internal slice:** one 8-bit carry-lookahead adder with carry-in. Per slice it computes g = a&b and p = a^b, derives the carries by lookahead, and forms sum = p ^ {c[6:0], cin}. There is exactly one instance; no wider adder is permitted.
- **State machine:** three states, IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - When in_valid is high, the block latches A, and latches B as in_b (add) or ~in_b (sub).
  - It loads carry = in_sub and idx = 0, then moves to RUN.
- **RUN**
  - Each cycle the slice adds byte idx of A, byte idx of B and carry.
  - The slice sum is written into byte idx of the sum register, carry takes the slice carry-out, and idx increments.
  - When idx = BYTES-1:
    - out_cout is set to the slice carry-out.
    - out_ovf is set to the slice's c[6] XOR c[7].
    - The state moves to DONE.
- **DONE**
  - out_valid = 1, and out_sum, out_cout and out_ovf are held stable.
  - When out_ready is high, the state returns to IDLE.
- **Input rules**
  - in_valid is ignored outside IDLE; no operation is queued.
  - in_a, in_b and in_sub are sampled only on the accepting edge. Later changes to these inputs do not affect the operation in flight.
- **Output rules**
  - out_sum, out_cout and out_ovf are registered.
  - Their values are unspecified while in RUN. They are defined whenever out_valid = 1.
- **Reset**
  - rst high forces the state to IDLE, idx = 0 and carry = 0.
  - It also clears out_sum, out_cout and out_ovf to 0.
  - rst has priority over every handshake in the same cycle.
  - in_ready and out_valid are 0 while rst is high.
- **Reset mid-operation:** the operation in RUN or DONE is discarded and no out_valid is produced for it. The first cycle after rst deasserts is IDLE with in_ready = 1.

## Timing
- The accepting edge is cycle T, where in_valid and in_ready are both high.
- RUN occupies cycles T+1 .. T+BYTES; byte k is computed in cycle T+1+k.
- out_valid rises in cycle T+BYTES+1. With BYTES=4 that is 5 cycles after accept.
- If out_ready is high on the first DONE cycle, the block is in IDLE the next cycle.
- Maximum throughput is one operation per BYTES+2 cycles.
- The DONE to IDLE transition and the next accept never occur in the same cycle.
- There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Test plan
All scenarios use BYTES=4.
1. **Single carry:** add 0x000000FF + 0x00000001 → out_sum = 0x00000100, cout = 0, ovf = 0. out_valid is first high exactly 5 cycles after the accepting edge.
2. **Full ripple:** add 0xFFFFFFFF + 0x00000001 → out_sum = 0x00000000, cout = 1, ovf = 0. This checks the carry chaining through all four bytes.
3. **Signed overflow:** add 0x7FFFFFFF + 0x00000001 → out_sum = 0x80000000, cout = 0, ovf = 1.
4. **Subtract:**
   - 0x00000005 - 0x00000007 → out_sum = 0xFFFFFFFE, cout = 0, ovf = 0.
   - 0x80000000 - 0x00000001 → out_sum = 0x7FFFFFFF, cout = 1, ovf = 1.
5. **Backpressure:** out_ready is held low for 10 cycles in DONE while in_valid is high with new operands.
   - out_valid and all outputs stay stable, and in_ready stays 0.
   - Then out_ready is pulsed: the next cycle is IDLE, and the new operation is accepted only after that.
6. **Reset mid-operation:** rst is asserted for one cycle while byte 2 is in RUN.
   - The next cycle has in_ready = 1, out_valid = 0 and out_sum = 0.
   - A following 0x12345678 + 0x11111111 completes as 0x23456789, cout = 0.
